// File: rtl/dmem_responder.sv
// Responder end of the data-memory load/store interface: one request at a time,
// WAIT_STATES idle cycles, then a byte-addressed access on an internal little-endian memory.
module dmem_responder #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DM_ADDRESS  = 9,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_error
);

    localparam int unsigned IDX_W     = DM_ADDRESS - 3;
    localparam int unsigned NUM_DW    = 1 << IDX_W;
    localparam int unsigned NUM_BYTES = DATA_W / 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  cap_write;
    logic [2:0]            cap_funct3;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [DATA_W-1:0]     mem [NUM_DW];

    logic                  access_c;
    logic                  err_c;
    logic                  do_write_c;
    logic [2:0]            lane_c;
    logic [IDX_W-1:0]      idx_c;
    logic [DATA_W-1:0]     dword_c;
    logic [DATA_W-1:0]     shifted_c;
    logic [DATA_W-1:0]     load_data_c;
    logic [DATA_W-1:0]     wshift_c;
    logic [7:0]            size_mask_c;
    logic [7:0]            byte_en_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)        state_next = BUSY;
            BUSY:    if (wait_cnt == '0)   state_next = RESP;
            RESP:    if (rsp_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Access decode from the captured request
    always_comb begin
        access_c    = (state == BUSY) && (wait_cnt == '0);
        lane_c      = cap_addr[2:0];
        idx_c       = cap_addr[DM_ADDRESS-1:3];
        dword_c     = mem[idx_c];
        shifted_c   = dword_c >> {lane_c, 3'b000};
        wshift_c    = cap_wdata << {lane_c, 3'b000};
        err_c       = 1'b0;
        size_mask_c = 8'h00;
        load_data_c = '0;
        case (cap_funct3[1:0])
            2'd0: begin
                size_mask_c = 8'h01;
                load_data_c = cap_funct3[2] ? DATA_W'(shifted_c[7:0])
                                            : {{(DATA_W-8){shifted_c[7]}}, shifted_c[7:0]};
            end
            2'd1: begin
                size_mask_c = 8'h03;
                err_c       = lane_c[0];
                load_data_c = cap_funct3[2] ? DATA_W'(shifted_c[15:0])
                                            : {{(DATA_W-16){shifted_c[15]}}, shifted_c[15:0]};
            end
            2'd2: begin
                size_mask_c = 8'h0F;
                err_c       = |lane_c[1:0];
                load_data_c = cap_funct3[2] ? DATA_W'(shifted_c[31:0])
                                            : {{(DATA_W-32){shifted_c[31]}}, shifted_c[31:0]};
            end
            default: begin
                size_mask_c = 8'hFF;
                err_c       = |lane_c;
                load_data_c = dword_c;
            end
        endcase
        // LDU does not exist, and stores have no unsigned form
        if (cap_funct3 == 3'b111 || (cap_write && cap_funct3[2])) begin
            err_c = 1'b1;
        end
        byte_en_c  = size_mask_c << lane_c;
        do_write_c = access_c && cap_write && !err_c;
    end

    // Request capture, wait counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            cap_write  <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cap_write  <= req_write;
                cap_funct3 <= req_funct3;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                wait_cnt   <= CNT_W'(WAIT_STATES);
            end
            if (state == BUSY && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (access_c) begin
                rsp_rdata <= (err_c || cap_write) ? '0 : load_data_c;
                rsp_error <= err_c;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_error <= 1'b0;
            end
        end
    end

    // Byte-enabled memory, cleared on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_DW); i++) begin
                mem[i] <= '0;
            end
        end else if (do_write_c) begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                if (byte_en_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wshift_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_STATES 2, 3 and 0.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  reset_v;
    logic [2:0]  req_valid_v;
    logic [2:0]  rsp_ready_v;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        req_ready_v [3];
    logic        rsp_valid_v [3];
    logic [63:0] rsp_rdata_v [3];
    logic        rsp_error_v [3];

    int checks = 0;
    int errors = 0;
    int ws [3] = '{2, 3, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(64), .DM_ADDRESS(9), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset_v[0]),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
        .rsp_rdata(rsp_rdata_v[0]), .rsp_error(rsp_error_v[0])
    );

    dmem_responder #(.DATA_W(64), .DM_ADDRESS(9), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset_v[1]),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
        .rsp_rdata(rsp_rdata_v[1]), .rsp_error(rsp_error_v[1])
    );

    dmem_responder #(.DATA_W(64), .DM_ADDRESS(9), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset_v[2]),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready_v[2]),
        .rsp_rdata(rsp_rdata_v[2]), .rsp_error(rsp_error_v[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, scramble inputs, time the response, hold bp cycles, handshake
    task automatic do_req(input int idx, input logic wr, input logic [2:0] f3,
                          input logic [8:0] addr, input logic [63:0] wd,
                          input logic [63:0] exp_rd, input logic exp_err,
                          input int bp, input string tag);
        int cyc;
        @(negedge clk);
        chk({tag, " req_ready_idle"}, 64'(req_ready_v[idx]), 64'd1);
        req_write        = wr;
        req_funct3       = f3;
        req_addr         = addr;
        req_wdata        = wd;
        req_valid_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[idx] = 1'b0;
        req_write        = ~wr;
        req_funct3       = ~f3;
        req_addr         = ~addr;
        req_wdata        = ~wd;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!rsp_valid_v[idx] && cyc < 40);
        chk({tag, " latency"}, 64'(cyc), 64'(ws[idx] + 1));
        if (rsp_valid_v[idx]) begin
            chk({tag, " rdata"}, rsp_rdata_v[idx], exp_rd);
            chk({tag, " error"}, 64'(rsp_error_v[idx]), 64'(exp_err));
            chk({tag, " req_ready_resp"}, 64'(req_ready_v[idx]), 64'd0);
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk({tag, " bp_valid"}, 64'(rsp_valid_v[idx]), 64'd1);
                chk({tag, " bp_rdata"}, rsp_rdata_v[idx], exp_rd);
                chk({tag, " bp_error"}, 64'(rsp_error_v[idx]), 64'(exp_err));
                chk({tag, " bp_req_ready"}, 64'(req_ready_v[idx]), 64'd0);
            end
            rsp_ready_v[idx] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready_v[idx] = 1'b0;
            @(negedge clk);
            chk({tag, " req_ready_after"}, 64'(req_ready_v[idx]), 64'd1);
            chk({tag, " rsp_valid_after"}, 64'(rsp_valid_v[idx]), 64'd0);
        end
    endtask

    initial begin
        reset_v     = 3'b000;
        req_valid_v = 3'b000;
        rsp_ready_v = 3'b000;
        req_write   = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 9'd0;
        req_wdata   = 64'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst req_ready", 64'(req_ready_v[k]), 64'd1);
            chk("rst rsp_valid", 64'(rsp_valid_v[k]), 64'd0);
            chk("rst rsp_rdata", rsp_rdata_v[k], 64'd0);
            chk("rst rsp_error", 64'(rsp_error_v[k]), 64'd0);
        end
        reset_v = 3'b111;

        // WAIT_STATES = 2
        do_req(0, 1'b1, 3'd3, 9'h010, 64'h1122334455667788, 64'd0, 1'b0, 0, "SD");
        do_req(0, 1'b0, 3'd3, 9'h010, 64'd0, 64'h1122334455667788, 1'b0, 0, "LD");
        do_req(0, 1'b1, 3'd0, 9'h013, 64'h55555555555555AB, 64'd0, 1'b0, 0, "SB");
        do_req(0, 1'b0, 3'd0, 9'h013, 64'd0, 64'hFFFFFFFFFFFFFFAB, 1'b0, 0, "LB");
        do_req(0, 1'b0, 3'd4, 9'h013, 64'd0, 64'h00000000000000AB, 1'b0, 0, "LBU");
        do_req(0, 1'b0, 3'd3, 9'h010, 64'd0, 64'h11223344AB667788, 1'b0, 0, "LD_after_SB");
        do_req(0, 1'b0, 3'd2, 9'h012, 64'd0, 64'd0, 1'b1, 0, "LW_misaligned");
        do_req(0, 1'b1, 3'd1, 9'h011, 64'h000000000000BEEF, 64'd0, 1'b1, 0, "SH_misaligned");
        do_req(0, 1'b0, 3'd3, 9'h010, 64'd0, 64'h11223344AB667788, 1'b0, 0, "LD_unchanged");
        do_req(0, 1'b0, 3'd7, 9'h010, 64'd0, 64'd0, 1'b1, 0, "funct3_111");
        do_req(0, 1'b1, 3'd4, 9'h010, 64'h00000000000000FF, 64'd0, 1'b1, 0, "SBU_illegal");
        do_req(0, 1'b1, 3'd3, 9'h014, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 0, "SD_misaligned");
        do_req(0, 1'b1, 3'd2, 9'h014, 64'h12345678CAFEF00D, 64'd0, 1'b0, 0, "SW");
        do_req(0, 1'b0, 3'd2, 9'h014, 64'd0, 64'hFFFFFFFFCAFEF00D, 1'b0, 0, "LW");
        do_req(0, 1'b0, 3'd6, 9'h014, 64'd0, 64'h00000000CAFEF00D, 1'b0, 0, "LWU");
        do_req(0, 1'b0, 3'd1, 9'h016, 64'd0, 64'hFFFFFFFFFFFFCAFE, 1'b0, 0, "LH");
        do_req(0, 1'b0, 3'd6, 9'h010, 64'd0, 64'h00000000AB667788, 1'b0, 0, "LWU_low");
        do_req(0, 1'b0, 3'd1, 9'h012, 64'd0, 64'hFFFFFFFFFFFFAB66, 1'b0, 0, "LH_12");
        do_req(0, 1'b1, 3'd3, 9'h1F8, 64'h0123456789ABCDEF, 64'd0, 1'b0, 0, "SD_top");
        do_req(0, 1'b0, 3'd5, 9'h1FE, 64'd0, 64'h0000000000000123, 1'b0, 0, "LHU_top");
        do_req(0, 1'b0, 3'd3, 9'h010, 64'd0, 64'hCAFEF00DAB667788, 1'b0, 5, "LD_backpressure");

        // WAIT_STATES = 3: reset while BUSY drops the store and clears memory
        do_req(1, 1'b1, 3'd3, 9'h028, 64'h0000000000001234, 64'd0, 1'b0, 0, "SD_pre_reset");
        do_req(1, 1'b0, 3'd3, 9'h028, 64'd0, 64'h0000000000001234, 1'b0, 0, "LD_pre_reset");
        @(negedge clk);
        req_write      = 1'b1;
        req_funct3     = 3'd3;
        req_addr       = 9'h020;
        req_wdata      = 64'h000000000000DEAD;
        req_valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[1] = 1'b0;
        @(negedge clk);
        reset_v[1] = 1'b0;
        #1;
        chk("midrst rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
        chk("midrst req_ready", 64'(req_ready_v[1]), 64'd1);
        chk("midrst rsp_rdata", rsp_rdata_v[1], 64'd0);
        @(negedge clk);
        reset_v[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("postrst rsp_valid", 64'(rsp_valid_v[1]), 64'd0);
        end
        do_req(1, 1'b0, 3'd3, 9'h020, 64'd0, 64'd0, 1'b0, 0, "LD_dropped");
        do_req(1, 1'b0, 3'd3, 9'h028, 64'd0, 64'd0, 1'b0, 0, "LD_cleared");

        // WAIT_STATES = 0
        do_req(2, 1'b1, 3'd3, 9'h010, 64'h1122334455667788, 64'd0, 1'b0, 0, "SD_ws0");
        do_req(2, 1'b0, 3'd5, 9'h010, 64'd0, 64'h0000000000007788, 1'b0, 2, "LHU_ws0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
